store_buffer: RTL and testbench

- Posted-write buffer directly downstream of the core's data-memory port; consumes MemWrite/MemRead/New_adr/WriteData from top.
- Queues stores in a small FIFO and drains them in order to the data memory / MMIO bus over a valid/ready handshake.
- Stalls the core only when the buffer is full.
- Forwards buffered data to loads that hit a pending store, and merges back-to-back stores to the same RAM word.

---
 rtl/store_buffer.sv | 156 +++++++++++++++
 tb/tb_store_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
// Posted-write buffer between the core's data-memory port and the data
// memory / MMIO bus. Stores are queued in a small circular FIFO and drained
// in program order over a valid/ready handshake. Back-to-back stores to the
// same RAM word merge into the youngest entry. Loads that hit a buffered
// store get the youngest matching data forwarded.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset (0 = reset)
//   MemWrite   core store request this cycle
//   MemRead    core load request this cycle
//   New_adr    core word address for load/store (MSB set = MMIO region)
//   WriteData  store data
//   Stall      core must hold its store (combinational)
//   fwd_hit    load hits a buffered store (combinational)
//   fwd_data   forwarded load data (combinational)
//   mem_valid  head entry presented downstream
//   mem_adr    head entry address
//   mem_wdata  head entry data
//   mem_ready  downstream accepts the head this cycle
//   count      number of valid entries
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 20,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic                     MemRead,
    input  logic [AW-1:0]            New_adr,
    input  logic [DW-1:0]            WriteData,
    output logic                     Stall,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_data,
    output logic                     mem_valid,
    output logic [AW-1:0]            mem_adr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]    adr_q  [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [CW-1:0]    count_q, count_d;

    logic [PW-1:0]    youngIdx;
    logic             pop;
    logic             merge;
    logic             push;

    // Handshake, merge and push decisions. The youngest entry sits just
    // behind the write pointer. A merge is refused when that entry is also
    // the head leaving this cycle, otherwise the new data would be lost.
    always_comb begin
        youngIdx  = wrPtr_q - PW'(1);
        mem_valid = (count_q != '0);
        pop       = mem_valid && mem_ready;
        merge     = MemWrite && (count_q != '0) &&
                    (New_adr == adr_q[youngIdx]) && !New_adr[AW-1] &&
                    !((count_q == CW'(1)) && pop);
        push      = MemWrite && !merge && ((count_q < FULL) || pop);
        Stall     = MemWrite && !merge && (count_q == FULL) && !pop;
    end

    // Head fields come straight from storage; forced to zero when empty so
    // the bus sees clean values while idle.
    always_comb begin
        mem_adr   = mem_valid ? adr_q[rdPtr_q]  : '0;
        mem_wdata = mem_valid ? data_q[rdPtr_q] : '0;
        count     = count_q;
    end

    // Next-state for pointers, valid bits and occupancy. With a full buffer
    // and simultaneous push+pop, both pointers coincide; the push is applied
    // after the pop so the slot ends up valid.
    always_comb begin
        valid_d = valid_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (pop) begin
            valid_d[rdPtr_q] = 1'b0;
            rdPtr_d          = rdPtr_q + PW'(1);
        end
        if (push) begin
            valid_d[wrPtr_q] = 1'b1;
            wrPtr_d          = wrPtr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Load forwarding: walk entries oldest to youngest so the last match
    // wins, which gives the youngest matching store. The head being popped
    // this cycle is still searched. MMIO loads always go to the bus.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (MemRead && !New_adr[AW-1]) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < count_q) &&
                    valid_q[rdPtr_q + PW'(i)] &&
                    (adr_q[rdPtr_q + PW'(i)] == New_adr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_q[rdPtr_q + PW'(i)];
                end
            end
        end
    end

    // State registers. Reset discards every pending entry; nothing that was
    // queued before reset is ever replayed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                adr_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            if (push) begin
                adr_q[wrPtr_q]  <= New_adr;
                data_q[wrPtr_q] <= WriteData;
            end else if (merge) begin
                data_q[youngIdx] <= WriteData;
            end
        end
    end

    // A load and a store in the same cycle is not a legal core request.
    noLoadStoreTogether: assert property (
        @(posedge clk) disable iff (!reset) !(MemWrite && MemRead)
    );

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
// Self-checking bench for store_buffer. Expected downstream writes are
// queued when the store is driven and compared as each head entry is
// accepted by the simulated memory.
// ---------------------------------------------------------------------------
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 20;
    localparam int DW    = 32;

    logic                   clk;
    logic                   reset;
    logic                   MemWrite;
    logic                   MemRead;
    logic [AW-1:0]          New_adr;
    logic [DW-1:0]          WriteData;
    logic                   Stall;
    logic                   fwd_hit;
    logic [DW-1:0]          fwd_data;
    logic                   mem_valid;
    logic [AW-1:0]          mem_adr;
    logic [DW-1:0]          mem_wdata;
    logic                   mem_ready;
    logic [$clog2(DEPTH):0] count;

    logic [AW+DW-1:0] expQ [$];
    int checkCount;
    int errorCount;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .New_adr   (New_adr),
        .WriteData (WriteData),
        .Stall     (Stall),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .mem_valid (mem_valid),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .count     (count)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic rd,
                                 input logic [AW-1:0] adr, input logic [DW-1:0] data);
        MemWrite  = wr;
        MemRead   = rd;
        New_adr   = adr;
        WriteData = data;
    endtask

    // One-cycle store; optionally records it as an expected bus write.
    task automatic storeWord(input logic [AW-1:0] adr, input logic [DW-1:0] data,
                             input bit expectIt);
        applyStimulus(1'b1, 1'b0, adr, data);
        if (expectIt) expQ.push_back({adr, data});
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
    endtask

    // Let the bus accept everything, bounded so a stuck DUT cannot hang us.
    task automatic drainAll();
        mem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (count == 0) break;
            tick();
        end
        checkOutput("drainDone", 64'(count), 64'd0);
        mem_ready = 1'b0;
    endtask

    // Downstream monitor: on each accepted head, compare against scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b1 && mem_valid === 1'b1 && mem_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWrite", 64'(mem_adr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [AW+DW-1:0] e;
                e = expQ.pop_front();
                checkOutput("popAdr", 64'(mem_adr), 64'(e[AW+DW-1:DW]));
                checkOutput("popData", 64'(mem_wdata), 64'(e[DW-1:0]));
            end
        end
    end

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset      = 1'b0;
        mem_ready  = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0);

        // Reset then idle
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idleCount", 64'(count), 64'd0);
            checkOutput("idleValid", 64'(mem_valid), 64'd0);
            checkOutput("idleStall", 64'(Stall), 64'd0);
            checkOutput("idleFwd", 64'(fwd_hit), 64'd0);
            checkOutput("idleAdr", 64'(mem_adr), 64'd0);
            tick();
        end

        // Single MMIO store with bus ready
        mem_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 20'h80064, 32'd25);
        expQ.push_back({20'h80064, 32'd25});
        @(negedge clk);
        checkOutput("mmioNoStall", 64'(Stall), 64'd0);
        checkOutput("mmioPreValid", 64'(mem_valid), 64'd0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("mmioValid", 64'(mem_valid), 64'd1);
        checkOutput("mmioAdr", 64'(mem_adr), 64'h80064);
        checkOutput("mmioData", 64'(mem_wdata), 64'd25);
        tick();
        checkOutput("mmioCountBack", 64'(count), 64'd0);
        mem_ready = 1'b0;

        // Fill and stall
        for (int w = 0; w < 4; w++) storeWord(AW'(w), DW'(10 + w), 1'b1);
        checkOutput("fillCount", 64'(count), 64'd4);
        applyStimulus(1'b1, 1'b0, 20'd4, 32'd14);
        expQ.push_back({20'd4, 32'd14});
        @(negedge clk);
        checkOutput("fullStall", 64'(Stall), 64'd1);
        tick();
        @(negedge clk);
        checkOutput("fullStallHeld", 64'(Stall), 64'd1);
        checkOutput("fullCountHeld", 64'(count), 64'd4);
        checkOutput("fullHeadStable", 64'(mem_adr), 64'd0);
        tick();
        mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("pushPopNoStall", 64'(Stall), 64'd0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("pushPopCount", 64'(count), 64'd4);
        checkOutput("pushPopHead", 64'(mem_adr), 64'd1);
        tick();
        drainAll();

        // Merge into youngest RAM entry
        storeWord(20'd8, 32'd5, 1'b0);
        storeWord(20'd8, 32'd7, 1'b1);
        checkOutput("mergeCount", 64'(count), 64'd1);
        checkOutput("mergeData", 64'(mem_wdata), 64'd7);
        drainAll();

        // MMIO stores to the same address never merge
        storeWord(20'h80060, 32'd1, 1'b1);
        storeWord(20'h80060, 32'd2, 1'b1);
        checkOutput("mmioNoMergeCount", 64'(count), 64'd2);
        drainAll();

        // Same RAM word while the only entry is leaving: must not merge
        storeWord(20'd12, 32'd1, 1'b1);
        mem_ready = 1'b1;
        storeWord(20'd12, 32'd2, 1'b1);
        mem_ready = 1'b0;
        checkOutput("noMergeOnPopCount", 64'(count), 64'd1);
        drainAll();

        // Forwarding
        storeWord(20'd16, 32'hAA, 1'b1);
        storeWord(20'd20, 32'hBB, 1'b1);
        storeWord(20'd16, 32'hCC, 1'b1);
        storeWord(20'h80030, 32'h55, 1'b1);
        checkOutput("fwdFillCount", 64'(count), 64'd4);
        applyStimulus(1'b0, 1'b1, 20'd16, '0);
        @(negedge clk);
        checkOutput("fwdHitYoung", 64'(fwd_hit), 64'd1);
        checkOutput("fwdDataYoung", 64'(fwd_data), 64'hCC);
        tick();
        applyStimulus(1'b0, 1'b1, 20'd20, '0);
        @(negedge clk);
        checkOutput("fwdHitMid", 64'(fwd_hit), 64'd1);
        checkOutput("fwdDataMid", 64'(fwd_data), 64'hBB);
        tick();
        applyStimulus(1'b0, 1'b1, 20'd24, '0);
        @(negedge clk);
        checkOutput("fwdMissHit", 64'(fwd_hit), 64'd0);
        checkOutput("fwdMissData", 64'(fwd_data), 64'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 20'h80030, '0);
        @(negedge clk);
        checkOutput("fwdMmioHit", 64'(fwd_hit), 64'd0);
        checkOutput("fwdMmioData", 64'(fwd_data), 64'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 20'd16, '0);
        @(negedge clk);
        checkOutput("fwdNoReadHit", 64'(fwd_hit), 64'd0);
        tick();
        drainAll();

        // Reset mid-operation discards pending entries
        storeWord(20'd40, 32'd1, 1'b1);
        storeWord(20'd44, 32'd2, 1'b1);
        storeWord(20'd48, 32'd3, 1'b1);
        checkOutput("preResetCount", 64'(count), 64'd3);
        reset = 1'b0;
        expQ.delete();
        tick();
        checkOutput("resetCount", 64'(count), 64'd0);
        checkOutput("resetValid", 64'(mem_valid), 64'd0);
        reset     = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("postResetValid", 64'(mem_valid), 64'd0);
            checkOutput("postResetCount", 64'(count), 64'd0);
            tick();
        end
        mem_ready = 1'b0;

        checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
